// File: rtl/effects_scheduler.sv
// Round-robin arbiter and sequencer sharing one effects engine among NREQ requesters.
// Optional watchdog abort enabled by defining EFFSCHED_TIMEOUT_EN.
module effects_scheduler #(
  parameter int NREQ           = 4,
  parameter int AW             = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_eff,
  input  logic [AW*NREQ-1:0] req_base,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic [2:0]        cur_id,
  output logic              eng_start,
  output logic [1:0]        eng_eff,
  output logic              eng_rst,
  input  logic              eng_done,
  input  logic [9:0]        eng_rd_adrr,
  input  logic [9:0]        eng_wr_adrr,
  output logic [AW-1:0]     mem_rd_addr,
  output logic [AW-1:0]     mem_wr_addr,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RUN,
    ACK
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    rr_q, rr_d;
  logic [2:0]    id_q, id_d;
  logic [1:0]    eff_q, eff_d;
  logic [AW-1:0] base_q, base_d;
  logic          first_q, first_d;

  logic [2:0]    sel;
  logic          found;
  int            idx;

`ifdef EFFSCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          tmo;
`endif

  // First requester at or above the RR pointer, wrapping at NREQ.
  always_comb begin
    sel   = 3'd0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_q) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = 3'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    eff_d     = eff_q;
    base_d    = base_q;
    first_d   = first_q;
    eng_start = 1'b0;
    eng_eff   = 2'b00;
    ack       = '0;
`ifdef EFFSCHED_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
    tmo       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          id_d    = sel;
          eff_d   = req_eff[2*sel +: 2];
          base_d  = req_base[AW*sel +: AW];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        eng_start = 1'b1;
        eng_eff   = eff_q;
        first_d   = 1'b1;
`ifdef EFFSCHED_TIMEOUT_EN
        cnt_d     = '0;
`endif
        state_d   = RUN;
      end
      RUN: begin
        eng_eff = eff_q;
        first_d = 1'b0;
        // done is still high on the first RUN cycle while the engine leaves idle
        if (!first_q && eng_done) state_d = ACK;
`ifdef EFFSCHED_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          tmo     = 1'b1;
          err_d   = 1'b1;
          state_d = ACK;
        end
        else cnt_d = cnt_q + 1'b1;
`endif
      end
      ACK: begin
        eng_eff = eff_q;
        ack     = NREQ'(1) << id_q;
        rr_d    = (id_q == 3'(NREQ - 1)) ? 3'd0 : id_q + 3'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 3'd0;
      id_q    <= 3'd0;
      eff_q   <= 2'b00;
      base_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      eff_q   <= eff_d;
      base_q  <= base_d;
      first_q <= first_d;
    end
  end

`ifdef EFFSCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign eng_rst = tmo;
  assign err     = err_q;
`else
  assign eng_rst = 1'b0;
  assign err     = 1'b0;
`endif

  assign busy        = (state_q != IDLE);
  assign cur_id      = id_q;
  assign mem_rd_addr = base_q + AW'(eng_rd_adrr);
  assign mem_wr_addr = base_q + AW'(eng_wr_adrr);

endmodule

// File: tb/tb_effects_scheduler.sv
// Bench for effects_scheduler: stub engine, grant scoreboard, relocation table.
// Define EFFSCHED_TIMEOUT_EN to exercise the watchdog build.
module tb_effects_scheduler;

  localparam int NREQ = 4;
  localparam int AW   = 16;
`ifdef EFFSCHED_TIMEOUT_EN
  localparam int TMO   = 50;
  localparam int LONG  = 40;
  localparam int RSTAT = 20;
`else
  localparam int TMO   = 1023;
  localparam int LONG  = 900;
  localparam int RSTAT = 100;
`endif

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_eff;
  logic [AW*NREQ-1:0] req_base;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic [2:0]        cur_id;
  logic              eng_start;
  logic [1:0]        eng_eff;
  logic              eng_rst;
  logic              eng_done;
  logic [9:0]        eng_rd_adrr;
  logic [9:0]        eng_wr_adrr;
  logic [AW-1:0]     mem_rd_addr;
  logic [AW-1:0]     mem_wr_addr;
  logic              err;

  effects_scheduler #(
    .NREQ(NREQ),
    .AW(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_eff(req_eff),
    .req_base(req_base),
    .ack(ack),
    .busy(busy),
    .cur_id(cur_id),
    .eng_start(eng_start),
    .eng_eff(eng_eff),
    .eng_rst(eng_rst),
    .eng_done(eng_done),
    .eng_rd_adrr(eng_rd_adrr),
    .eng_wr_adrr(eng_wr_adrr),
    .mem_rd_addr(mem_rd_addr),
    .mem_wr_addr(mem_wr_addr),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub engine: runs len pixels after a start, done low meanwhile.
  int          len;
  logic        hold;
  logic        man;
  logic [9:0]  man_rd;
  logic [9:0]  man_wr;
  logic [10:0] ecnt;
  logic [10:0] elen;

  always_ff @(posedge clk) begin
    if (rst || eng_rst) begin
      ecnt <= '0;
      elen <= '0;
    end else if (eng_start) begin
      ecnt <= 11'(len);
      elen <= 11'(len);
    end else if (ecnt != 0) begin
      ecnt <= ecnt - 1'b1;
    end
  end

  assign eng_done    = hold ? 1'b0 : (ecnt == 0);
  assign eng_rd_adrr = man ? man_rd : 10'(elen - ecnt);
  assign eng_wr_adrr = man ? man_wr : 10'(elen - ecnt);

  typedef struct {
    logic [2:0] id;
    logic [1:0] eff;
  } grant_t;

  typedef struct {
    logic [15:0] base;
    logic [9:0]  rd;
    logic [9:0]  wr;
    logic [15:0] erd;
    logic [15:0] ewr;
  } vec_t;

  grant_t     exp_q[$];
  logic [2:0] run_id;
  int         n_cmp;
  int         n_bad;
  int         nack;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] id, input logic [1:0] eff);
    grant_t g;
    g.id  = id;
    g.eff = eff;
    exp_q.push_back(g);
  endtask

  // One clock: monitor grants/acks; requester drops req on its ack.
  task automatic cyc();
    grant_t g;
    @(posedge clk);
    #1;
    if (eng_start) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_grant: got id %0d want none", cur_id);
      end else begin
        g = exp_q.pop_front();
        chk("grant_id", 32'(cur_id), 32'(g.id));
        chk("grant_eff", 32'(eng_eff), 32'(g.eff));
        run_id = g.id;
      end
    end
    if (ack != 0) begin
      chk("ack_onehot", 32'(ack), 32'(4'(1) << run_id));
      nack++;
      req = req & ~ack;
    end
  endtask

  task automatic wait_acks(input int n, input int budget);
    int target;
    int k;
    target = nack + n;
    k = 0;
    while (nack < target && k < budget) begin
      cyc();
      k++;
    end
    chk("ack_wait", 32'(nack >= target), 32'd1);
  endtask

  task automatic wait_start(input int budget);
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!eng_start && k < budget);
    chk("start_wait", 32'(eng_start), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   k;
    logic got;
    logic seen;

    vecs[0] = '{16'hFF00, 10'h000, 10'h0FF, 16'hFF00, 16'hFFFF};
    vecs[1] = '{16'hFF00, 10'h3FF, 10'h100, 16'h02FF, 16'h0000};
    vecs[2] = '{16'h1000, 10'h000, 10'h383, 16'h1000, 16'h1383};
    vecs[3] = '{16'hFC01, 10'h3FF, 10'h3FE, 16'h0000, 16'hFFFF};
    vecs[4] = '{16'h0000, 10'h2AA, 10'h155, 16'h02AA, 16'h0155};
    vecs[5] = '{16'h7FFF, 10'h001, 10'h3FF, 16'h8000, 16'h83FE};

    n_cmp = 0;
    n_bad = 0;
    nack = 0;
    run_id = 3'd0;
    rst = 1'b1;
    req = '0;
    req_eff = '0;
    req_base = '0;
    len = 5;
    hold = 1'b0;
    man = 1'b0;
    man_rd = '0;
    man_wr = '0;

    repeat (3) cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", 32'({ack, cur_id, eng_start, eng_eff, eng_rst, err}), 32'd0);
    rst = 1'b0;
    cyc();

    // single long job on requester 0
    len = LONG;
    req_eff[1:0] = 2'b01;
    req_base[15:0] = 16'h1000;
    req[0] = 1'b1;
    push(3'd0, 2'b01);
    k = 0;
    got = 1'b0;
    while (k < LONG + 10 && !got) begin
      cyc();
      k++;
      if (k == 1) chk("t1_start_lat", 32'(eng_start), 32'd1);
      if (k == 2) chk("t1_rd_first", 32'(mem_rd_addr), 32'h1000);
      if (k == LONG + 1) chk("t1_rd_last", 32'(mem_rd_addr), 32'(16'h1000 + LONG - 1));
      if (ack != 0) begin
        got = 1'b1;
        chk("t1_ack_lat", 32'(k), 32'(LONG + 3));
      end
    end
    chk("t1_acked", 32'(got), 32'd1);
    cyc();
    chk("idle_eff", 32'({busy, eng_eff}), 32'd0);

    // all four request from reset: 0,1,2,3 then 0 again
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    len = 5;
    req_eff = {2'b00, 2'b11, 2'b10, 2'b01};
    for (int i = 0; i < NREQ; i++) req_base[AW*i +: AW] = 16'(16'h2000 * (i + 1));
    req = 4'hF;
    push(3'd0, 2'b01);
    push(3'd1, 2'b10);
    push(3'd2, 2'b11);
    push(3'd3, 2'b00);
    wait_acks(1, 40);
    req[0] = 1'b1;
    push(3'd0, 2'b01);
    cyc();
    chk("gap_idle", 32'(busy), 32'd0);
    cyc();
    chk("gap_start", 32'(eng_start), 32'd1);
    wait_acks(4, 100);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // grant 2, then 3 and 0 arrive while busy; base change ignored
    len = 0;
    hold = 1'b1;
    man = 1'b1;
    man_wr = 10'h055;
    req[2] = 1'b1;
    push(3'd2, 2'b11);
    wait_start(10);
    cyc();
    req[3] = 1'b1;
    req[0] = 1'b1;
    req_base[AW*2 +: AW] = 16'hABCD;
    req_eff[5:4] = 2'b00;
    push(3'd3, 2'b00);
    push(3'd0, 2'b01);
    cyc();
    chk("t3_wr_reloc", 32'(mem_wr_addr), 32'h6055);
    chk("t3_eff_held", 32'(eng_eff), 32'b11);
    hold = 1'b0;
    man = 1'b0;
    wait_acks(3, 60);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // relocation table on requester 1
    for (int i = 0; i < 6; i++) begin
      len = 0;
      hold = 1'b1;
      man = 1'b1;
      man_rd = '0;
      man_wr = '0;
      req_base[AW*1 +: AW] = vecs[i].base;
      req_eff[3:2] = 2'(i);
      req[1] = 1'b1;
      push(3'd1, 2'(i));
      wait_start(10);
      cyc();
      man_rd = vecs[i].rd;
      man_wr = vecs[i].wr;
      #1;
      chk($sformatf("reloc_rd%0d", i), 32'(mem_rd_addr), 32'(vecs[i].erd));
      chk($sformatf("reloc_wr%0d", i), 32'(mem_wr_addr), 32'(vecs[i].ewr));
      chk($sformatf("reloc_err%0d", i), 32'(err), 32'd0);
      hold = 1'b0;
      man = 1'b0;
      wait_acks(1, 20);
    end

    // reset in the middle of a job, then a fresh job
    len = LONG;
    req_base[15:0] = 16'h3000;
    req[0] = 1'b1;
    push(3'd0, 2'b01);
    wait_start(10);
    repeat (RSTAT) cyc();
    rst = 1'b1;
    req = '0;
    cyc();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ack", 32'(ack), 32'd0);
    rst = 1'b0;
    len = 5;
    req[3] = 1'b1;
    push(3'd3, 2'b00);
    wait_acks(1, 30);

    // engine that never finishes
    req_eff[5:4] = 2'b11;
    hold = 1'b1;
    len = 0;
    req[2] = 1'b1;
    push(3'd2, 2'b11);
    wait_start(10);
`ifdef EFFSCHED_TIMEOUT_EN
    k = 0;
    seen = 1'b0;
    got = 1'b0;
    while (k < 100 && !got) begin
      cyc();
      k++;
      if (eng_rst && !seen) begin
        seen = 1'b1;
        chk("tmo_cycle", 32'(k), 32'(TMO));
      end
      if (ack != 0) begin
        got = 1'b1;
        chk("tmo_ack_cycle", 32'(k), 32'(TMO + 1));
        chk("tmo_err_set", 32'(err), 32'd1);
      end
    end
    chk("tmo_seen", 32'({seen, got}), 32'b11);
    hold = 1'b0;
    repeat (5) cyc();
    chk("tmo_err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    cyc();
    chk("tmo_err_clr", 32'(err), 32'd0);
    rst = 1'b0;
    cyc();
`else
    seen = 1'b0;
    got = 1'b0;
    k = 0;
    repeat (300) cyc();
    chk("hang_busy", 32'(busy), 32'd1);
    chk("hang_rst_err", 32'({eng_rst, err}), 32'd0);
    hold = 1'b0;
    wait_acks(1, 10);
`endif

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
